base12_alu_dispatcher: RTL and testbench

- Command front-end sitting directly upstream of base12_alu.
- Buffers ALU commands from the control path in a small FIFO, issues them one at a time over the ALU's enable/done protocol, captures each result and returns it tagged on a valid/ready result port.
- Guarantees operands and opcode stay stable while enable is high, and enforces the enable-low gap the ALU needs between operations.
- Adds a completion watchdog.

---
 rtl/base12_alu_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_base12_alu_dispatcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base12_alu_dispatcher.sv
// Command front-end for base12_alu: buffers commands, issues them one at a time over
// enable/done, and returns tagged results. Define BASE12_DISP_OPCHECK_EN to reject opcodes > 8 locally.
module base12_alu_dispatcher #(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_op,
  input  logic [31:0]                  cmd_a,
  input  logic [31:0]                  cmd_b,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_data,
  output logic [TAG_W-1:0]             res_tag,
  output logic                         res_err,
  output logic                         alu_enable,
  output logic [3:0]                   alu_operation,
  output logic [31:0]                  alu_operand_a,
  output logic [31:0]                  alu_operand_b,
  input  logic [31:0]                  alu_result,
  input  logic                         alu_done,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_OUTPUT
  } state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem [CMD_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           state_next;
  logic [7:0]       watchdog;
  logic [TAG_W-1:0] tag_q;
  logic             head_illegal;
  logic             do_issue;
  logic             do_reject;
  logic             do_done;
  logic             do_abort;

  assign head       = mem[rd_ptr];
  assign cmd_ready  = (count != CNT_W'(CMD_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = count;
  assign busy       = (state != S_IDLE) || (count != '0);

`ifdef BASE12_DISP_OPCHECK_EN
  assign head_illegal = (head.op > 4'd8);
`else
  assign head_illegal = 1'b0;
`endif

  // NOTE: the command storage carries no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    case (state)
      S_IDLE: begin
        // A still-high done belongs to the previous operation; wait for the ALU to clear it.
        if (count != '0 && !alu_done) begin
          pop        = 1'b1;
          state_next = head_illegal ? S_OUTPUT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_done) begin
          do_done    = 1'b1;
          state_next = S_OUTPUT;
        end else if (watchdog == 8'(TIMEOUT)) begin
          do_abort   = 1'b1;
          state_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign do_issue  = pop && !head_illegal;
  assign do_reject = pop && head_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_enable    <= 1'b0;
      alu_operation <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      tag_q         <= '0;
      watchdog      <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_tag       <= '0;
      res_err       <= 1'b0;
    end else begin
      if (do_issue) begin
        alu_enable    <= 1'b1;
        alu_operation <= head.op;
        alu_operand_a <= head.a;
        alu_operand_b <= head.b;
        tag_q         <= head.tag;
        watchdog      <= '0;
      end else if (state == S_ISSUE) begin
        watchdog <= watchdog + 8'd1;
      end

      if (do_done) begin
        alu_enable <= 1'b0;
        res_valid  <= 1'b1;
        res_data   <= alu_result;
        res_tag    <= tag_q;
        res_err    <= 1'b0;
      end else if (do_abort) begin
        alu_enable <= 1'b0;
        res_valid  <= 1'b1;
        res_data   <= '0;
        res_tag    <= tag_q;
        res_err    <= 1'b1;
      end else if (do_reject) begin
        res_valid  <= 1'b1;
        res_data   <= '0;
        res_tag    <= head.tag;
        res_err    <= 1'b1;
      end else if (state == S_OUTPUT && res_ready) begin
        res_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_base12_alu_dispatcher.sv
// Directed bench for base12_alu_dispatcher with a behavioural base12_alu model
// (3-cycle arith/logic, 2-cycle XOR/shift, 1-cycle unknown opcodes).
module tb_base12_alu_dispatcher;

  localparam int CMD_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int TIMEOUT   = 15;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       cmd_valid = 1'b0;
  logic                       cmd_ready;
  logic [3:0]                 cmd_op = '0;
  logic [31:0]                cmd_a = '0;
  logic [31:0]                cmd_b = '0;
  logic [TAG_W-1:0]           cmd_tag = '0;
  logic                       res_valid;
  logic                       res_ready = 1'b0;
  logic [31:0]                res_data;
  logic [TAG_W-1:0]           res_tag;
  logic                       res_err;
  logic                       alu_enable;
  logic [3:0]                 alu_operation;
  logic [31:0]                alu_operand_a;
  logic [31:0]                alu_operand_b;
  logic [31:0]                alu_result;
  logic                       alu_done;
  logic                       busy;
  logic [$clog2(CMD_DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  base12_alu_dispatcher #(
    .CMD_DEPTH(CMD_DEPTH),
    .TAG_W    (TAG_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_tag      (cmd_tag),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .res_err      (res_err),
    .alu_enable   (alu_enable),
    .alu_operation(alu_operation),
    .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b),
    .alu_result   (alu_result),
    .alu_done     (alu_done),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // ALU model: counts enabled cycles, raises done at its latency, clears once enable is seen low.
  logic [7:0]  m_cnt  = '0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic        stuck  = 1'b0;

  function automatic logic [7:0] alu_lat(input logic [3:0] op);
    if (op <= 4'd5) return 8'd3;
    if (op <= 4'd8) return 8'd2;
    return 8'd1;
  endfunction

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!alu_enable) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (!m_done) begin
      m_cnt <= m_cnt + 8'd1;
      if (m_cnt + 8'd1 == alu_lat(alu_operation)) begin
        m_done <= 1'b1;
        m_res  <= alu_calc(alu_operation, alu_operand_a, alu_operand_b);
      end
    end
  end

  assign alu_done   = m_done && !stuck;
  assign alu_result = m_res;

  // Enable monitor: total enabled cycles and the shortest low gap between two enable pulses.
  int en_cycles = 0;
  int low_run   = 0;
  int min_gap   = 1000;
  bit seen_en   = 1'b0;

  always @(negedge clk) begin
    if (alu_enable) begin
      en_cycles <= en_cycles + 1;
      if (seen_en && low_run != 0 && low_run < min_gap) min_gap <= low_run;
      seen_en <= 1'b1;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) check("push_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Edges after the push edge until res_valid is seen high.
  task automatic wait_latency(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (res_valid) break;
    end
  endtask

  task automatic get_result(input string tag, input logic [31:0] exp_data,
                            input logic [TAG_W-1:0] exp_tag, input logic exp_err);
    for (int i = 0; i < 200 && !res_valid; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"},  res_data, exp_data);
    check({tag, "_tag"},   32'(res_tag), 32'(exp_tag));
    check({tag, "_err"},   32'(res_err), 32'(exp_err));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int en_before;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_alu_enable", 32'(alu_enable), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_res_data",   res_data,        32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single ADD, consumer always ready.
    res_ready = 1'b1;
    push(4'd0, 32'd7, 32'd5, 4'd3);
    wait_latency(n);
    check("add_latency",    32'(n),          32'd5);
    check("add_data",       res_data,        32'd12);
    check("add_tag",        32'(res_tag),    32'd3);
    check("add_err",        32'(res_err),    32'd0);
    check("add_enable_low", 32'(alu_enable), 32'd0);
    @(posedge clk); #1;
    check("add_accepted",   32'(res_valid),  32'd0);
    settle();

    // XOR and shifts complete one cycle sooner.
    push(4'd6, 32'h0000_F0F0, 32'h0000_FF0F, 4'd4);
    wait_latency(n);
    check("xor_latency", 32'(n),   32'd4);
    check("xor_data",    res_data, 32'h0000_0FFF);
    settle();
    push(4'd7, 32'd1, 32'd4, 4'd5);
    wait_latency(n);
    check("shl_data", res_data, 32'd16);
    settle();
    push(4'd8, 32'h8000_0000, 32'd31, 4'd6);
    wait_latency(n);
    check("shr_data", res_data, 32'd1);
    settle();

    // Unknown opcode 12.
    en_before = en_cycles;
    push(4'd12, 32'd99, 32'd1, 4'd9);
    wait_latency(n);
`ifdef BASE12_DISP_OPCHECK_EN
    check("op12_latency", 32'(n),       32'd1);
    check("op12_err",     32'(res_err), 32'd1);
`else
    check("op12_latency", 32'(n),       32'd3);
    check("op12_err",     32'(res_err), 32'd0);
`endif
    check("op12_data", res_data,      32'd0);
    check("op12_tag",  32'(res_tag),  32'd9);
    settle();
`ifdef BASE12_DISP_OPCHECK_EN
    check("op12_enable_cycles", 32'(en_cycles - en_before), 32'd0);
`else
    check("op12_enable_cycles", 32'(en_cycles - en_before), 32'd2);
`endif

    // Fill the FIFO while results are held back.
    res_ready = 1'b0;
    push(4'd0, 32'd1,    32'd2,    4'd1);
    push(4'd1, 32'd5,    32'd7,    4'd2);
    push(4'd2, 32'd6,    32'd7,    4'd3);
    push(4'd4, 32'hFF,   32'h0F,   4'd4);
    push(4'd5, 32'hF0,   32'h0F,   4'd5);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(cmd_ready),  32'd0);
    check("full_busy",  32'(busy),       32'd1);
    get_result("q0", 32'd3,           4'd1, 1'b0);
    get_result("q1", 32'hFFFF_FFFE,   4'd2, 1'b0);
    get_result("q2", 32'd42,          4'd3, 1'b0);
    get_result("q3", 32'h0F,          4'd4, 1'b0);
    get_result("q4", 32'hFF,          4'd5, 1'b0);
    settle();

    // Division including divide-by-zero.
    push(4'd3, 32'd144, 32'd12, 4'd10);
    push(4'd3, 32'd10,  32'd0,  4'd11);
    get_result("div0", 32'd12,         4'd10, 1'b0);
    get_result("div1", 32'hFFFF_FFFF,  4'd11, 1'b0);
    settle();

    // Watchdog abort with done held low, then normal recovery.
    stuck     = 1'b1;
    res_ready = 1'b1;
    en_before = en_cycles;
    push(4'd0, 32'd1, 32'd1, 4'd6);
    wait_latency(n);
    check("wd_latency", 32'(n),        32'(TIMEOUT + 2));
    check("wd_err",     32'(res_err),  32'd1);
    check("wd_data",    res_data,      32'd0);
    check("wd_tag",     32'(res_tag),  32'd6);
    settle();
    check("wd_enable_cycles", 32'(en_cycles - en_before), 32'(TIMEOUT + 1));
    stuck = 1'b0;
    push(4'd1, 32'd10, 32'd3, 4'd7);
    wait_latency(n);
    check("post_wd_latency", 32'(n),       32'd5);
    check("post_wd_data",    res_data,     32'd7);
    check("post_wd_err",     32'(res_err), 32'd0);
    settle();

    // Reset while one command is in ISSUE and two are queued.
    res_ready = 1'b0;
    push(4'd0, 32'd1, 32'd1, 4'd1);
    push(4'd0, 32'd2, 32'd2, 4'd2);
    push(4'd0, 32'd3, 32'd3, 4'd3);
    check("pre_rst_count",  32'(fifo_count), 32'd2);
    check("pre_rst_enable", 32'(alu_enable), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_enable", 32'(alu_enable), 32'd0);
    check("mid_rst_count",  32'(fifo_count), 32'd0);
    check("mid_rst_valid",  32'(res_valid),  32'd0);
    check("mid_rst_ready",  32'(cmd_ready),  32'd1);
    check("mid_rst_busy",   32'(busy),       32'd0);
    settle();
    push(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 4'd2);
    get_result("post_rst", 32'h0000_F000, 4'd2, 1'b0);
    settle();

    check("min_enable_gap", 32'(min_gap), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
